wctl_dvstack_unit: RTL and testbench

- Divergence (IPDOM) stack responder on the scheduler side of the warp-control interface.
- Consumes split/join commands issued by the warp-control execute unit.
- Returns the current per-warp stack pointer for the dvstack query.
- Emits registered thread-mask and PC updates back to the warp scheduler.
- Holds one independent stack per warp.

---
 rtl/wctl_dvstack_unit.sv | 105 ++++++++++
 tb/tb_wctl_dvstack_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wctl_dvstack_unit.sv
// wctl_dvstack_unit: per-warp IPDOM divergence stack answering split/join commands with registered scheduler updates.
// Optional DVSTACK_PERF_EN adds max_depth and split_dvg_count outputs.
module wctl_dvstack_unit #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 30,
  parameter int STACK_SIZE  = 8,
  localparam int PTRW = $clog2(STACK_SIZE + 1),
  localparam int WW   = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WW-1:0]          dvstack_wid,
  output logic [PTRW-1:0]        dvstack_ptr,
  input  logic                   ctl_valid,
  input  logic [WW-1:0]          ctl_wid,
  input  logic [NUM_THREADS-1:0] curr_tmask,
  input  logic                   split_valid,
  input  logic                   split_is_dvg,
  input  logic [NUM_THREADS-1:0] split_then_tmask,
  input  logic [NUM_THREADS-1:0] split_else_tmask,
  input  logic [PC_BITS-1:0]     split_next_pc,
  input  logic                   join_valid,
  input  logic [PTRW-1:0]        join_stack_ptr,
  output logic                   upd_valid,
  output logic [WW-1:0]          upd_wid,
  output logic [NUM_THREADS-1:0] upd_tmask,
  output logic                   upd_pc_valid,
  output logic [PC_BITS-1:0]     upd_pc,
  output logic                   overflow
`ifdef DVSTACK_PERF_EN
  ,
  output logic [PTRW-1:0]        max_depth,
  output logic [31:0]            split_dvg_count
`endif
);
  localparam int SW = $clog2(STACK_SIZE);
  localparam logic [PTRW-1:0] ONE   = PTRW'(1);
  localparam logic [PTRW-1:0] TWO   = PTRW'(2);
  localparam logic [PTRW-1:0] LIMIT = PTRW'(STACK_SIZE - 2);
  logic [PTRW-1:0]        r_ptr      [NUM_WARPS];
  logic [NUM_THREADS-1:0] r_st_tmask [NUM_WARPS][STACK_SIZE];
  logic [PC_BITS-1:0]     r_st_pc    [NUM_WARPS][STACK_SIZE];
  logic                   r_st_ft    [NUM_WARPS][STACK_SIZE];
  logic [PTRW-1:0] w_ptr;
  logic [SW-1:0]   w_lo, w_top;
  logic            w_join, w_split, w_dvg, w_full, w_push, w_pop, w_top_ft;
  assign dvstack_ptr = r_ptr[dvstack_wid];
  // join wins over a simultaneous split; a pop needs a non-empty stack and a pointer past the split mark
  always_comb begin
    w_ptr    = r_ptr[ctl_wid];
    w_join   = ctl_valid & join_valid;
    w_split  = ctl_valid & split_valid & ~join_valid;
    w_dvg    = w_split & split_is_dvg;
    w_full   = w_ptr > LIMIT;
    w_push   = w_dvg & ~w_full;
    w_pop    = w_join & (w_ptr != join_stack_ptr) & (w_ptr != '0);
    w_lo     = w_ptr[SW-1:0];
    w_top    = SW'(w_ptr - ONE);
    w_top_ft = r_st_ft[ctl_wid][w_top];
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_st_tmask[ctl_wid][w_lo]           <= curr_tmask;
      r_st_pc[ctl_wid][w_lo]              <= '0;
      r_st_ft[ctl_wid][w_lo]              <= 1'b1;
      r_st_tmask[ctl_wid][w_lo + SW'(1)]  <= split_else_tmask;
      r_st_pc[ctl_wid][w_lo + SW'(1)]     <= split_next_pc;
      r_st_ft[ctl_wid][w_lo + SW'(1)]     <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) r_ptr[i] <= '0;
      upd_valid    <= 1'b0;
      upd_wid      <= '0;
      upd_tmask    <= '0;
      upd_pc_valid <= 1'b0;
      upd_pc       <= '0;
      overflow     <= 1'b0;
    end else begin
      if (w_push) r_ptr[ctl_wid] <= w_ptr + TWO;
      else if (w_pop) r_ptr[ctl_wid] <= w_ptr - ONE;
      upd_valid    <= w_split | w_pop;
      upd_pc_valid <= w_pop & ~w_top_ft;
      if (w_split | w_pop) begin
        upd_wid   <= ctl_wid;
        upd_tmask <= w_pop ? r_st_tmask[ctl_wid][w_top] : split_then_tmask;
      end
      if (w_pop & ~w_top_ft) upd_pc <= r_st_pc[ctl_wid][w_top];
      if (w_dvg & w_full) overflow <= 1'b1;
    end
  end
`ifdef DVSTACK_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      max_depth       <= '0;
      split_dvg_count <= '0;
    end else begin
      if (w_push && (w_ptr + TWO) > max_depth) max_depth <= w_ptr + TWO;
      if (w_dvg && !(&split_dvg_count)) split_dvg_count <= split_dvg_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wctl_dvstack_unit.sv
// tb_wctl_dvstack_unit: directed and randomized checks of the divergence stack against a queue-based model.
module tb_wctl_dvstack_unit;
  logic        clk = 0, reset = 1;
  logic [1:0]  dvstack_wid = 0, ctl_wid = 0, upd_wid;
  logic [3:0]  dvstack_ptr, join_stack_ptr = 0;
  logic        ctl_valid = 0, split_valid = 0, split_is_dvg = 0, join_valid = 0;
  logic [3:0]  curr_tmask = 0, split_then_tmask = 0, split_else_tmask = 0, upd_tmask;
  logic [29:0] split_next_pc = 0, upd_pc;
  logic        upd_valid, upd_pc_valid, overflow;

  wctl_dvstack_unit dut (
    .clk(clk), .reset(reset), .dvstack_wid(dvstack_wid), .dvstack_ptr(dvstack_ptr),
    .ctl_valid(ctl_valid), .ctl_wid(ctl_wid), .curr_tmask(curr_tmask),
    .split_valid(split_valid), .split_is_dvg(split_is_dvg),
    .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask),
    .split_next_pc(split_next_pc), .join_valid(join_valid), .join_stack_ptr(join_stack_ptr),
    .upd_valid(upd_valid), .upd_wid(upd_wid), .upd_tmask(upd_tmask),
    .upd_pc_valid(upd_pc_valid), .upd_pc(upd_pc), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] tmask; logic [29:0] pc; logic ft;} ent_t;
  ent_t        stk [4][$];
  logic        exp_valid, exp_pcv, exp_ovf = 0;
  logic [3:0]  exp_tmask;
  logic [29:0] exp_pc;
  logic [1:0]  exp_wid;
  int          n_checks = 0, n_fail = 0;

  task automatic model_cmd(input int wid, input bit sv, dvg, jv, input int jsp,
                           input logic [3:0] curr, th, el, input logic [29:0] npc);
    ent_t e;
    exp_valid = 0; exp_pcv = 0; exp_wid = 2'(wid);
    if (jv) begin
      if (stk[wid].size() != jsp && stk[wid].size() != 0) begin
        e = stk[wid].pop_back();
        exp_valid = 1; exp_tmask = e.tmask; exp_pcv = !e.ft; exp_pc = e.pc;
      end
    end else if (sv) begin
      exp_valid = 1; exp_tmask = th;
      if (dvg) begin
        if (stk[wid].size() + 2 <= 8) begin
          stk[wid].push_back('{curr, 30'd0, 1'b1});
          stk[wid].push_back('{el, npc, 1'b0});
        end else exp_ovf = 1;
      end
    end
  endtask

  task automatic set_cmd(input int wid, input bit sv, dvg, jv, input int jsp,
                         input logic [3:0] curr, th, el, input logic [29:0] npc);
    ctl_valid = 1; ctl_wid = 2'(wid); split_valid = sv; split_is_dvg = dvg; join_valid = jv;
    join_stack_ptr = 4'(jsp); curr_tmask = curr; split_then_tmask = th;
    split_else_tmask = el; split_next_pc = npc;
    model_cmd(wid, sv, dvg, jv, jsp, curr, th, el, npc);
  endtask

  task automatic drive(input int wid, input bit sv, dvg, jv, input int jsp,
                       input logic [3:0] curr, th, el, input logic [29:0] npc);
    set_cmd(wid, sv, dvg, jv, jsp, curr, th, el, npc);
    @(posedge clk); @(negedge clk);
    ctl_valid = 0; split_valid = 0; join_valid = 0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({upd_valid, upd_pc_valid, overflow, upd_wid, upd_tmask, upd_pc} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b pcv=%b ovf=%b wid=%0d tm=%b pc=%h, want all 0",
                         upd_valid, upd_pc_valid, overflow, upd_wid, upd_tmask, upd_pc);
    end
    for (int w = 0; w < 4; w++) begin
      dvstack_wid = 2'(w); #1; n_checks++;
      if (dvstack_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_ptr w%0d: got %0d want 0", w, dvstack_ptr); end
    end
  endtask

  task automatic test_nondiv_split;
    drive(1, 1, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000, 30'h0);
    n_checks++;
    if ({upd_valid, upd_pc_valid, upd_wid, upd_tmask} !== {1'b1, 1'b0, 2'd1, 4'b1111}) begin
      n_fail++; $display("FAIL nondiv_upd: got v=%b pcv=%b wid=%0d tm=%b want 1 0 1 1111",
                         upd_valid, upd_pc_valid, upd_wid, upd_tmask);
    end
    dvstack_wid = 1; #1; n_checks++;
    if (dvstack_ptr !== 4'd0) begin n_fail++; $display("FAIL nondiv_ptr: got %0d want 0", dvstack_ptr); end
    @(posedge clk); @(negedge clk); n_checks++;
    if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL upd_pulse: got %b want 0", upd_valid); end
  endtask

  task automatic test_div_join;
    dvstack_wid = 0;
    set_cmd(0, 1, 1, 0, 0, 4'b1111, 4'b0011, 4'b1100, 30'h100);
    #1; n_checks++;
    if (dvstack_ptr !== 4'd0) begin n_fail++; $display("FAIL no_forward: got %0d want 0", dvstack_ptr); end
    @(posedge clk); @(negedge clk);
    ctl_valid = 0; split_valid = 0;
    n_checks++;
    if ({upd_valid, upd_pc_valid, upd_wid, upd_tmask} !== {1'b1, 1'b0, 2'd0, 4'b0011}) begin
      n_fail++; $display("FAIL div_upd: got v=%b pcv=%b wid=%0d tm=%b want 1 0 0 0011",
                         upd_valid, upd_pc_valid, upd_wid, upd_tmask);
    end
    #1; n_checks++;
    if (dvstack_ptr !== 4'd2) begin n_fail++; $display("FAIL div_ptr: got %0d want 2", dvstack_ptr); end
    drive(0, 0, 0, 1, 0, 4'b0, 4'b0, 4'b0, 30'h0);
    n_checks++;
    if ({upd_valid, upd_pc_valid, upd_tmask, upd_pc} !== {1'b1, 1'b1, 4'b1100, 30'h100}) begin
      n_fail++; $display("FAIL join1: got v=%b pcv=%b tm=%b pc=%h want 1 1 1100 100",
                         upd_valid, upd_pc_valid, upd_tmask, upd_pc);
    end
    #1; n_checks++;
    if (dvstack_ptr !== 4'd1) begin n_fail++; $display("FAIL join1_ptr: got %0d want 1", dvstack_ptr); end
    drive(0, 0, 0, 1, 0, 4'b0, 4'b0, 4'b0, 30'h0);
    n_checks++;
    if ({upd_valid, upd_pc_valid, upd_tmask} !== {1'b1, 1'b0, 4'b1111}) begin
      n_fail++; $display("FAIL join2: got v=%b pcv=%b tm=%b want 1 0 1111", upd_valid, upd_pc_valid, upd_tmask);
    end
    #1; n_checks++;
    if (dvstack_ptr !== 4'd0) begin n_fail++; $display("FAIL join2_ptr: got %0d want 0", dvstack_ptr); end
    drive(0, 0, 0, 1, 0, 4'b0, 4'b0, 4'b0, 30'h0);
    n_checks++;
    if ({upd_valid, upd_pc_valid} !== 2'b00) begin
      n_fail++; $display("FAIL join_empty: got v=%b pcv=%b want 0 0", upd_valid, upd_pc_valid);
    end
  endtask

  task automatic test_overflow;
    for (int k = 0; k < 5; k++) begin
      drive(2, 1, 1, 0, 0, 4'b1111, 4'(k + 1), 4'(14 - k), 30'(k * 16));
      n_checks++;
      if ({upd_valid, upd_pc_valid, upd_wid, upd_tmask} !== {1'b1, 1'b0, 2'd2, 4'(k + 1)}) begin
        n_fail++; $display("FAIL ovf_split%0d: got v=%b pcv=%b wid=%0d tm=%b want tm=%b",
                           k, upd_valid, upd_pc_valid, upd_wid, upd_tmask, 4'(k + 1));
      end
      dvstack_wid = 2; #1; n_checks++;
      if ({dvstack_ptr, overflow} !== {4'(k < 4 ? 2 * k + 2 : 8), 1'(k == 4)}) begin
        n_fail++; $display("FAIL ovf_state%0d: got ptr=%0d ovf=%b want ptr=%0d ovf=%b",
                           k, dvstack_ptr, overflow, (k < 4 ? 2 * k + 2 : 8), k == 4);
      end
    end
    drive(2, 0, 0, 1, 8, 4'b0, 4'b0, 4'b0, 30'h0);
    #1; n_checks++;
    if ({upd_valid, dvstack_ptr} !== {1'b0, 4'd8}) begin
      n_fail++; $display("FAIL join_noop: got v=%b ptr=%0d want 0 8", upd_valid, dvstack_ptr);
    end
  endtask

  task automatic test_back_to_back;
    drive(0, 1, 1, 0, 0, 4'b1010, 4'b1000, 4'b0010, 30'h200);
    drive(3, 1, 1, 0, 0, 4'b0111, 4'b0001, 4'b0110, 30'h300);
    n_checks++;
    if ({upd_valid, upd_wid, upd_tmask} !== {1'b1, 2'd3, 4'b0001}) begin
      n_fail++; $display("FAIL b2b_upd: got v=%b wid=%0d tm=%b want 1 3 0001", upd_valid, upd_wid, upd_tmask);
    end
    drive(3, 0, 0, 1, 0, 4'b0, 4'b0, 4'b0, 30'h0);
    n_checks++;
    if ({upd_valid, upd_pc_valid, upd_wid, upd_tmask, upd_pc} !== {1'b1, 1'b1, 2'd3, 4'b0110, 30'h300}) begin
      n_fail++; $display("FAIL b2b_pop3a: got v=%b pcv=%b wid=%0d tm=%b pc=%h", upd_valid, upd_pc_valid, upd_wid, upd_tmask, upd_pc);
    end
    drive(3, 0, 0, 1, 0, 4'b0, 4'b0, 4'b0, 30'h0);
    n_checks++;
    if ({upd_valid, upd_pc_valid, upd_tmask} !== {1'b1, 1'b0, 4'b0111}) begin
      n_fail++; $display("FAIL b2b_pop3b: got v=%b pcv=%b tm=%b want 1 0 0111", upd_valid, upd_pc_valid, upd_tmask);
    end
    dvstack_wid = 0; #1; n_checks++;
    if (dvstack_ptr !== 4'd2) begin n_fail++; $display("FAIL b2b_ptr0: got %0d want 2", dvstack_ptr); end
    drive(0, 0, 0, 1, 0, 4'b0, 4'b0, 4'b0, 30'h0);
    n_checks++;
    if ({upd_valid, upd_pc_valid, upd_wid, upd_tmask, upd_pc} !== {1'b1, 1'b1, 2'd0, 4'b0010, 30'h200}) begin
      n_fail++; $display("FAIL b2b_pop0a: got v=%b pcv=%b wid=%0d tm=%b pc=%h", upd_valid, upd_pc_valid, upd_wid, upd_tmask, upd_pc);
    end
    drive(0, 0, 0, 1, 0, 4'b0, 4'b0, 4'b0, 30'h0);
    n_checks++;
    if ({upd_valid, upd_pc_valid, upd_tmask} !== {1'b1, 1'b0, 4'b1010}) begin
      n_fail++; $display("FAIL b2b_pop0b: got v=%b pcv=%b tm=%b want 1 0 1010", upd_valid, upd_pc_valid, upd_tmask);
    end
  endtask

  task automatic test_reset_mid;
    drive(1, 1, 1, 0, 0, 4'b1111, 4'b0101, 4'b1010, 30'h40);
    reset = 1;
    set_cmd(1, 0, 0, 1, 0, 4'b0, 4'b0, 4'b0, 30'h0);
    @(posedge clk); @(negedge clk);
    ctl_valid = 0; join_valid = 0; reset = 0;
    for (int w = 0; w < 4; w++) stk[w].delete();
    exp_ovf = 0;
    n_checks++;
    if ({upd_valid, upd_pc_valid, overflow} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid: got v=%b pcv=%b ovf=%b want 0 0 0", upd_valid, upd_pc_valid, overflow);
    end
    for (int w = 0; w < 4; w++) begin
      dvstack_wid = 2'(w); #1; n_checks++;
      if (dvstack_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_mid_ptr w%0d: got %0d want 0", w, dvstack_ptr); end
    end
  endtask

  task automatic test_random;
    int r, wid, sz, jsp, q;
    bit jv, sv;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        exp_valid = 0; exp_pcv = 0;
        @(posedge clk); @(negedge clk);
      end else begin
        wid = $urandom_range(0, 3);
        sz = stk[wid].size();
        jv = (r < 5);
        sv = jv ? 1'($urandom_range(0, 1)) : 1'b1;
        jsp = ($urandom_range(0, 3) == 0) ? sz : $urandom_range(0, 8);
        drive(wid, sv, 1'($urandom_range(0, 3) != 0), jv, jsp, 4'($urandom), 4'($urandom),
              4'($urandom), 30'($urandom));
      end
      n_checks++;
      if (upd_valid !== exp_valid || upd_pc_valid !== exp_pcv || overflow !== exp_ovf ||
          (exp_valid && (upd_wid !== exp_wid || upd_tmask !== exp_tmask)) ||
          (exp_pcv && upd_pc !== exp_pc)) begin
        n_fail++; $display("FAIL rand_upd it%0d: got v=%b pcv=%b ovf=%b wid=%0d tm=%b pc=%h want v=%b pcv=%b ovf=%b wid=%0d tm=%b pc=%h",
                           it, upd_valid, upd_pc_valid, overflow, upd_wid, upd_tmask, upd_pc,
                           exp_valid, exp_pcv, exp_ovf, exp_wid, exp_tmask, exp_pc);
      end
      q = $urandom_range(0, 3);
      dvstack_wid = 2'(q); #1; n_checks++;
      if (dvstack_ptr !== 4'(stk[q].size())) begin
        n_fail++; $display("FAIL rand_ptr it%0d w%0d: got %0d want %0d", it, q, dvstack_ptr, stk[q].size());
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    test_reset;
    test_nondiv_split;
    test_div_join;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
